// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO, sitting beside the EX-stage ALU.
// One bit per cycle (shift-add multiply, restoring divide), then a sign-fix cycle that writes HI/LO.
`timescale 1ns/1ps
module ex_muldiv_unit #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_MDOP = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [BITS_MDOP-1:0] i_md_op,
  input  logic [BITS_SIZE-1:0] i_data_a,
  input  logic [BITS_SIZE-1:0] i_data_b,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BITS_SIZE-1:0] o_result,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  localparam int W  = BITS_SIZE;
  localparam int CW = $clog2(W) + 1;

  localparam logic [BITS_MDOP-1:0] OP_MULT  = BITS_MDOP'(0);
  localparam logic [BITS_MDOP-1:0] OP_MULTU = BITS_MDOP'(1);
  localparam logic [BITS_MDOP-1:0] OP_DIV   = BITS_MDOP'(2);
  localparam logic [BITS_MDOP-1:0] OP_DIVU  = BITS_MDOP'(3);
  localparam logic [BITS_MDOP-1:0] OP_MFHI  = BITS_MDOP'(4);
  localparam logic [BITS_MDOP-1:0] OP_MFLO  = BITS_MDOP'(5);
  localparam logic [BITS_MDOP-1:0] OP_MTHI  = BITS_MDOP'(6);
  localparam logic [BITS_MDOP-1:0] OP_MTLO  = BITS_MDOP'(7);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   hi_q, lo_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;

  // Datapath: acc holds {partial product | multiplier} or {remainder | quotient}.
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   b_mag_q;
  logic           is_div_q, div_zero_q, neg_res_q, neg_rem_q;

  logic           idle, start, start_signed, start_div, a_neg, b_neg, b_zero;
  logic [W-1:0]   a_mag, b_mag;
  logic [W-1:0]   madd_term;
  logic [W:0]     madd;
  logic [2*W-1:0] mult_next, div_next;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [W-1:0]   fix_hi, fix_lo;

  assign idle         = (state_q == IDLE);
  assign start        = idle && i_valid && (i_md_op <= OP_DIVU);
  assign start_signed = (i_md_op == OP_MULT) || (i_md_op == OP_DIV);
  assign start_div    = (i_md_op == OP_DIV) || (i_md_op == OP_DIVU);
  assign a_neg        = start_signed && i_data_a[W-1];
  assign b_neg        = start_signed && i_data_b[W-1];
  assign a_mag        = a_neg ? -i_data_a : i_data_a;
  assign b_mag        = b_neg ? -i_data_b : i_data_b;
  assign b_zero       = (i_data_b == '0);

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
  assign madd_term = acc_q[0] ? b_mag_q : '0;
  assign madd      = {1'b0, acc_q[2*W-1:W]} + {1'b0, madd_term};
  assign mult_next = {madd, acc_q[W-1:1]};

  // Restoring step: trial-subtract the divisor from the shifted remainder.
  assign div_ge   = (acc_q[2*W-1:W-1] >= {1'b0, b_mag_q});
  assign div_diff = acc_q[2*W-2:W-1] - b_mag_q;
  assign div_next = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                           : {acc_q[2*W-2:0], 1'b0};

  always_comb begin
    fix_hi = acc_q[2*W-1:W];
    fix_lo = acc_q[W-1:0];
    if (div_zero_q) begin
      fix_hi = acc_q[W-1:0];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_lo = neg_res_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
      fix_hi = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = -acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (start_div && b_zero) ? FIX : RUN;
      RUN:     if (cnt_q == CW'(W - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      if (start)               cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
      if (state_q == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (idle && i_valid && (i_md_op == OP_MTHI)) begin
        hi_q <= i_data_a;
      end else if (idle && i_valid && (i_md_op == OP_MTLO)) begin
        lo_q <= i_data_a;
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; the FSM guarantees they are loaded before use.
  always_ff @(posedge i_clk) begin
    if (start) begin
      acc_q      <= {{W{1'b0}}, (start_div && b_zero) ? i_data_a : a_mag};
      b_mag_q    <= b_mag;
      is_div_q   <= start_div;
      div_zero_q <= start_div && b_zero;
      neg_res_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
    end else if (state_q == RUN) begin
      acc_q <= is_div_q ? div_next : mult_next;
    end
  end

  always_comb begin
    o_result = '0;
    if (idle && i_valid) begin
      if (i_md_op == OP_MFHI)      o_result = hi_q;
      else if (i_md_op == OP_MFLO) o_result = lo_q;
    end
  end

  assign o_busy  = !idle;
  assign o_stall = o_busy && i_valid;
  assign o_done  = done_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: HI/LO moves, mult/div results, stall timing, div-by-zero, reset abort.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [2:0]  i_md_op;
  logic [31:0] i_data_a, i_data_b;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_result, o_hi, o_lo;

  int total = 0;
  int bad   = 0;
  int n, done_cnt, done_at, stall_seen;

  ex_muldiv_unit #(.BITS_SIZE(32), .BITS_MDOP(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_md_op(i_md_op),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .o_stall(o_stall), .o_busy(o_busy),
    .o_done(o_done), .o_result(o_result), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1ns after it, away from the sampling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid  = v;
    i_md_op  = op;
    i_data_a = a;
    i_data_b = b;
  endtask

  // Counts edges after start until o_done is seen; 0 means it never came.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (o_done) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_hi", o_hi, 0);
    check("rst_lo", o_lo, 0);

    // 1: moves to and from HI/LO
    drive(1'b1, 3'd6, 32'h0000_1234, 32'hDEAD_BEEF);
    #1 check("mthi_stall", o_stall, 0);
    tick();
    drive(1'b1, 3'd7, 32'h0000_ABCD, 32'h0);
    #1 check("mtlo_stall", o_stall, 0);
    tick();
    drive(1'b1, 3'd4, 32'h5555_5555, 32'h0);
    #1 check("mfhi_result", o_result, 32'h0000_1234);
    check("mfhi_stall", o_stall, 0);
    tick();
    drive(1'b1, 3'd5, 32'h0, 32'h0);
    #1 check("mflo_result", o_result, 32'h0000_ABCD);
    tick();
    drive(1'b0, 3'd5, 32'h0, 32'h0);
    #1 check("idle_result_zero", o_result, 0);

    // 2: signed MULT in background, 40 unrelated instructions behind it
    drive(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7);
    #1 check("mult_start_stall", o_stall, 0);
    tick();
    check("mult_busy", o_busy, 1);
    done_cnt = 0; done_at = 0; stall_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      #1 if (o_stall) stall_seen++;
      tick();
      if (o_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check("mult_done_count", done_cnt, 1);
    check("mult_done_edge", done_at, 33);
    check("mult_no_stall", stall_seen, 0);
    check("mult_hi", o_hi, 32'hFFFF_FFFF);
    check("mult_lo", o_lo, 32'hFFFF_FFEB);

    // 3: MULTU max x max
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_done(n);
    check("multu_latency", n, 33);
    check("multu_hi", o_hi, 32'hFFFF_FFFE);
    check("multu_lo", o_lo, 32'h0000_0001);

    // 4: DIV -7/2 followed immediately by a dependent MFLO
    drive(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    tick();
    drive(1'b1, 3'd5, 32'h1234_5678, 32'h0);
    n = 0;
    #1;
    while (o_stall && n < 60) begin
      n++;
      tick();
    end
    check("div_stall_cycles", n, 33);
    check("div_done_on_release", o_done, 1);
    check("div_mflo_result", o_result, 32'hFFFF_FFFD);
    check("div_hi", o_hi, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #1 check("div_done_one_cycle", o_done, 0);

    // 5: divide by zero and signed overflow case
    drive(1'b1, 3'd3, 32'd5, 32'd0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("divz_busy_fix", o_busy, 1);
    wait_done(n);
    check("divz_latency", n, 1);
    check("divz_lo", o_lo, 32'hFFFF_FFFF);
    check("divz_hi", o_hi, 32'd5);
    drive(1'b1, 3'd2, 32'hFFFF_FFF8, 32'd0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_done(n);
    check("sdivz_hi_raw", o_hi, 32'hFFFF_FFF8);
    check("sdivz_lo", o_lo, 32'hFFFF_FFFF);
    drive(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_done(n);
    check("divovf_latency", n, 33);
    check("divovf_lo", o_lo, 32'h8000_0000);
    check("divovf_hi", o_hi, 32'h0);
    drive(1'b1, 3'd3, 32'd100, 32'd7);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_done(n);
    check("divu_lo", o_lo, 32'd14);
    check("divu_hi", o_hi, 32'd2);

    // 6: reset in the middle of a MULT aborts it
    drive(1'b1, 3'd0, 32'd5, 32'd9);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_hi", o_hi, 0);
    check("abort_lo", o_lo, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    drive(1'b1, 3'd0, 32'd6, 32'd7);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_done(n);
    check("mult67_latency", n, 33);
    check("mult67_lo", o_lo, 32'd42);
    check("mult67_hi", o_hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
